btn_counter: RTL and testbench

Parametrised, button-driven up/down counter. Three raw push-button inputs (up, down, clear) pass through per-button synchroniser/debounce/edge logic with optional hold-to-repeat, and the resulting pulses drive a modulo counter that wraps or saturates. All logic runs in the single `clk` domain using clock enables; there are no derived clocks. The block sits between board buttons and the display/LCD drivers and replaces ad-hoc prescaled-clock counters.

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/btn_conditioner.sv | 79 +++++++
 rtl/btn_counter.sv | 123 ++++++++++++
 tb/tb_btn_counter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and helpers for the board-button / display slice.
package lcd_pkg;

    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_CLR  = 2'd3
    } step_e;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw button to one-cycle press pulses: 2-flop synchroniser, debounce,
// rising-edge detect and optional hold-to-repeat.
module btn_conditioner
    import lcd_pkg::*;
#(
    parameter int DEB_CYCLES    = 1000000,
    parameter int HOLD_CYCLES   = 0,
    parameter int REPEAT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int DEB_W = clog2(DEB_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_r;
    logic [DEB_W-1:0] deb_cnt_r;
    logic             deb_r;
    logic             deb_prev_r;
    logic             press_r;
    logic             rep_fire_s;

    // Synchroniser, stable-level debounce counter and press register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r     <= 2'b00;
            deb_cnt_r  <= '0;
            deb_r      <= 1'b0;
            deb_prev_r <= 1'b0;
            press_r    <= 1'b0;
        end else begin
            sync_r     <= {sync_r[0], btn};
            if (sync_r[1] == deb_r) begin
                deb_cnt_r <= '0;
            end else if (deb_cnt_r == DEB_LAST) begin
                deb_cnt_r <= '0;
                deb_r     <= ~deb_r;
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
            end
            deb_prev_r <= deb_r;
            press_r    <= (deb_r & ~deb_prev_r) | rep_fire_s;
        end
    end

    if (HOLD_CYCLES > 0) begin : g_repeat
        localparam int HOLD_W = clog2(HOLD_CYCLES + 1);
        localparam int REP_W  = clog2(REPEAT_CYCLES);
        localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
        localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYCLES - 1);

        logic [HOLD_W-1:0] hold_cnt_r;
        logic [REP_W-1:0]  rep_cnt_r;

        // Hold timer saturates at HOLD_CYCLES, then the repeat phase counter cycles.
        always_ff @(posedge clk) begin
            if (rst || !deb_r) begin
                hold_cnt_r <= '0;
                rep_cnt_r  <= '0;
            end else if (hold_cnt_r != HOLD_MAX) begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
            end else if (rep_cnt_r == REP_LAST) begin
                rep_cnt_r <= '0;
            end else begin
                rep_cnt_r <= rep_cnt_r + REP_W'(1);
            end
        end

        assign rep_fire_s = deb_r && (hold_cnt_r == HOLD_MAX) && (rep_cnt_r == '0);
    end else begin : g_no_repeat
        assign rep_fire_s = 1'b0;
    end

    assign press = press_r;

endmodule

// File: rtl/btn_counter.sv
// Button-driven modulo up/down counter with wrap or saturate at the limits.
module btn_counter
    import lcd_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int MODULUS       = 16,
    parameter int SATURATE      = 0,
    parameter int DEB_CYCLES    = 1000000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_clr,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             borrow,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

    logic             up_press_s;
    logic             down_press_s;
    logic             clr_press_s;
    step_e            step_s;
    logic [WIDTH-1:0] count_next_s;
    logic             carry_next_s;
    logic             borrow_next_s;
    logic [WIDTH-1:0] count_r;
    logic             carry_r;
    logic             borrow_r;

    btn_conditioner #(
        .DEB_CYCLES   (DEB_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_up (.clk(clk), .rst(rst), .btn(btn_up), .press(up_press_s));

    btn_conditioner #(
        .DEB_CYCLES   (DEB_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_down (.clk(clk), .rst(rst), .btn(btn_down), .press(down_press_s));

    btn_conditioner #(
        .DEB_CYCLES   (DEB_CYCLES),
        .HOLD_CYCLES  (0),
        .REPEAT_CYCLES(1)
    ) u_clr (.clk(clk), .rst(rst), .btn(btn_clr), .press(clr_press_s));

    // Clear wins; opposing up/down presses in one cycle cancel.
    always_comb begin
        step_s = STEP_NONE;
        if (clr_press_s) begin
            step_s = STEP_CLR;
        end else if (up_press_s && !down_press_s) begin
            step_s = STEP_UP;
        end else if (down_press_s && !up_press_s) begin
            step_s = STEP_DOWN;
        end else begin
            step_s = STEP_NONE;
        end
    end

    // Limits are checked before stepping so count never leaves 0..MODULUS-1.
    always_comb begin
        count_next_s  = count_r;
        carry_next_s  = 1'b0;
        borrow_next_s = 1'b0;
        case (step_s)
            STEP_CLR: begin
                count_next_s = '0;
            end
            STEP_UP: begin
                if (count_r != CNT_MAX) begin
                    count_next_s = count_r + WIDTH'(1);
                end else if (SATURATE == CNT_SAT) begin
                    count_next_s = count_r;
                end else begin
                    count_next_s = '0;
                    carry_next_s = 1'b1;
                end
            end
            STEP_DOWN: begin
                if (count_r != '0) begin
                    count_next_s = count_r - WIDTH'(1);
                end else if (SATURATE == CNT_SAT) begin
                    count_next_s = count_r;
                end else begin
                    count_next_s  = CNT_MAX;
                    borrow_next_s = 1'b1;
                end
            end
            default: begin
                count_next_s = count_r;
            end
        endcase
    end

    // Count and wrap pulses are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= '0;
            carry_r  <= 1'b0;
            borrow_r <= 1'b0;
        end else begin
            count_r  <= count_next_s;
            carry_r  <= carry_next_s;
            borrow_r <= borrow_next_s;
        end
    end

    assign count  = count_r;
    assign carry  = carry_r;
    assign borrow = borrow_r;
    assign at_max = (count_r == CNT_MAX);
    assign at_min = (count_r == '0);

endmodule

// File: tb/tb_btn_counter.sv
// Scoreboard bench: a wrapping and a saturating counter share one set of
// buttons; expected per-cycle outputs are queued when buttons are driven.
module tb_btn_counter;

    localparam int MOD      = 10;
    localparam int ACT_NONE = 0;
    localparam int ACT_UP   = 1;
    localparam int ACT_DN   = 2;
    localparam int ACT_CLR  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       btn_clr;
    logic [3:0] count_w;
    logic       carry_w;
    logic       borrow_w;
    logic       at_max_w;
    logic       at_min_w;
    logic [3:0] count_s;
    logic       carry_s;
    logic       borrow_s;
    logic       at_max_s;
    logic       at_min_s;

    typedef struct {
        int    cyc;
        string tag;
        int    cnt_w;
        int    car_w;
        int    bor_w;
        int    cnt_s;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mdl_w    = 0;
    int   mdl_s    = 0;

    btn_counter #(
        .WIDTH(4), .MODULUS(MOD), .SATURATE(0),
        .DEB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
    ) dut_wrap (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
        .count(count_w), .carry(carry_w), .borrow(borrow_w), .at_max(at_max_w), .at_min(at_min_w)
    );

    btn_counter #(
        .WIDTH(4), .MODULUS(MOD), .SATURATE(1),
        .DEB_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5)
    ) dut_sat (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
        .count(count_s), .carry(carry_s), .borrow(borrow_s), .at_max(at_max_s), .at_min(at_min_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_state(input int at, input string tag, input int cw, input int bw);
        exp_t e;
        e.cyc   = at;
        e.tag   = tag;
        e.cnt_w = mdl_w;
        e.car_w = cw;
        e.bor_w = bw;
        e.cnt_s = mdl_s;
        sb.push_back(e);
    endtask

    // Expected outputs around one count step at cycle 'at'.
    task automatic schedule_step(input int at, input int act, input string tag);
        int cw;
        int bw;
        cw = 0;
        bw = 0;
        push_state(at - 1, {tag, "_pre"}, 0, 0);
        case (act)
            ACT_UP: begin
                if (mdl_w == MOD - 1) begin mdl_w = 0; cw = 1; end
                else mdl_w = mdl_w + 1;
                if (mdl_s != MOD - 1) mdl_s = mdl_s + 1;
            end
            ACT_DN: begin
                if (mdl_w == 0) begin mdl_w = MOD - 1; bw = 1; end
                else mdl_w = mdl_w - 1;
                if (mdl_s != 0) mdl_s = mdl_s - 1;
            end
            ACT_CLR: begin
                mdl_w = 0;
                mdl_s = 0;
            end
            default: ;
        endcase
        push_state(at, tag, cw, bw);
        push_state(at + 1, {tag, "_post"}, 0, 0);
    endtask

    // Pop every entry that has come due and compare both counters.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            check_eq({mon_e.tag, "_due"}, cyc, mon_e.cyc);
            check_eq({mon_e.tag, "_count_w"}, count_w, mon_e.cnt_w);
            check_eq({mon_e.tag, "_carry_w"}, carry_w, mon_e.car_w);
            check_eq({mon_e.tag, "_borrow_w"}, borrow_w, mon_e.bor_w);
            check_eq({mon_e.tag, "_atmax_w"}, at_max_w, (mon_e.cnt_w == MOD - 1));
            check_eq({mon_e.tag, "_atmin_w"}, at_min_w, (mon_e.cnt_w == 0));
            check_eq({mon_e.tag, "_count_s"}, count_s, mon_e.cnt_s);
            check_eq({mon_e.tag, "_carry_s"}, carry_s, 0);
            check_eq({mon_e.tag, "_borrow_s"}, borrow_s, 0);
            check_eq({mon_e.tag, "_atmax_s"}, at_max_s, (mon_e.cnt_s == MOD - 1));
            check_eq({mon_e.tag, "_atmin_s"}, at_min_s, (mon_e.cnt_s == 0));
        end
    end

    // Clean press held 10 cycles; btns = {clr, down, up}.
    task automatic press(input logic [2:0] btns, input int act, input string tag);
        int c;
        @(negedge clk);
        c = cyc;
        {btn_clr, btn_down, btn_up} = btns;
        schedule_step(c + 8, act, tag);
        repeat (10) @(negedge clk);
        {btn_clr, btn_down, btn_up} = 3'b000;
        repeat (16) @(negedge clk);
        push_state(cyc + 1, {tag, "_idle"}, 0, 0);
        @(negedge clk);
    endtask

    // Up held: first step at +8, repeats every 5 from +28, then release.
    task automatic hold_up(input int n_steps, input int rel, input string tag);
        int c;
        @(negedge clk);
        c = cyc;
        btn_up = 1'b1;
        schedule_step(c + 8, ACT_UP, tag);
        for (int k = 0; k < n_steps - 1; k++) begin
            schedule_step(c + 28 + 5 * k, ACT_UP, tag);
        end
        repeat (rel) @(negedge clk);
        btn_up = 1'b0;
        repeat (16) @(negedge clk);
        push_state(cyc + 1, {tag, "_idle"}, 0, 0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_clr  = 1'b0;
        repeat (3) @(negedge clk);
        push_state(cyc + 1, "reset", 0, 0);
        rst = 1'b0;

        press(3'b001, ACT_UP, "latency");

        // Bounce every 2 cycles, settle high, then bouncy release.
        @(negedge clk);
        c = cyc;
        push_state(c + 20, "bounce_quiet", 0, 0);
        schedule_step(c + 28, ACT_UP, "bounce");
        for (int i = 0; i < 20; i++) begin
            btn_up = ((i / 2) % 2 == 0);
            @(negedge clk);
        end
        btn_up = 1'b1;
        repeat (8) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            btn_up = ((j / 2) % 2 == 1);
            @(negedge clk);
        end
        btn_up = 1'b0;
        repeat (16) @(negedge clk);
        push_state(cyc + 1, "bounce_release", 0, 0);
        @(negedge clk);

        press(3'b011, ACT_NONE, "up_and_down");
        press(3'b101, ACT_CLR, "clr_with_up");
        press(3'b010, ACT_DN, "down_at_zero");
        hold_up(5, 38, "repeat5");

        // Reset in the middle of a debounce window.
        @(negedge clk);
        c = cyc;
        push_state(c + 3, "rst_before", 0, 0);
        btn_up = 1'b1;
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        mdl_w = 0;
        mdl_s = 0;
        push_state(c + 4, "rst_mid", 0, 0);
        @(negedge clk);
        rst = 1'b0;
        schedule_step(c + 12, ACT_UP, "rst_repress");
        repeat (10) @(negedge clk);
        btn_up = 1'b0;
        repeat (16) @(negedge clk);
        push_state(cyc + 1, "rst_idle", 0, 0);
        @(negedge clk);

        hold_up(8, 54, "repeat8");
        press(3'b001, ACT_UP, "up_at_max");
        press(3'b010, ACT_DN, "down_after_wrap");

        repeat (3) @(negedge clk);
        @(posedge clk);
        check_eq("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
